// File: rtl/mix_sequencer.sv
// mix_sequencer: per-sample controller for the octaver datapath.
// Each tick: ADC conversion, octave fetch, saturating mix, 16-bit serial DAC frame.
module mix_sequencer #(
    parameter int unsigned SAMPLE_DIV = 2500,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [3:0]  DAC_CMD    = 4'b0011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mix_en,
    input  logic [13:0] adc_data,
    input  logic        adc_done,
    output logic        adc_start,
    input  logic [11:0] oct_data,
    input  logic        oct_valid,
    output logic        oct_req,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_sdi,
    output logic [11:0] mix_out,
    output logic        timeout_err,
    output logic        overrun
);
    localparam int unsigned        WAIT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [15:0]        TICK_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_OCT   = 3'd2,
        ST_SUM   = 3'd3,
        ST_SHIFT = 3'd4
    } state_t;

    function automatic logic [11:0] to_offset_binary(input logic [11:0] twos);
        to_offset_binary = twos ^ 12'h800;
    endfunction

    function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] sum;
        sum       = {1'b0, a} + {1'b0, b};
        sat_add12 = sum[12] ? 12'hFFF : sum[11:0];
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [11:0]       orig_q, orig_d;
    logic [11:0]       oct_q, oct_d;
    logic [15:0]       frame_q, frame_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic              adc_start_q, adc_start_d;
    logic              oct_req_q, oct_req_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              sdi_q, sdi_d;
    logic [11:0]       mix_q, mix_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;

    logic              tick_s;
    logic [11:0]       mix_sum_s;
    logic [15:0]       frame_load_s;
    // The two ADC LSBs sit below the 12-bit output resolution.
    logic              unused_adc_lsb_s;

    assign unused_adc_lsb_s = ^adc_data[1:0];

    assign adc_start   = adc_start_q;
    assign oct_req     = oct_req_q;
    assign dac_cs_n    = cs_n_q;
    assign dac_sclk    = sclk_q;
    assign dac_sdi     = sdi_q;
    assign mix_out     = mix_q;
    assign timeout_err = err_q;
    assign overrun     = ovr_q;

    // Free-running sample-period counter; tick marks its last count.
    always_comb begin
        tick_s = (tick_cnt_q == TICK_LAST);
        if (tick_s) begin
            tick_cnt_d = 16'd0;
        end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        orig_d       = orig_q;
        oct_d        = oct_q;
        frame_d      = frame_q;
        bit_cnt_d    = bit_cnt_q;
        adc_start_d  = 1'b0;
        oct_req_d    = 1'b0;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        sdi_d        = sdi_q;
        mix_d        = mix_q;
        err_d        = err_q;
        ovr_d        = tick_s && (state_q != ST_IDLE);
        mix_sum_s    = sat_add12(orig_q, oct_q);
        frame_load_s = {DAC_CMD, mix_sum_s};

        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    adc_start_d = 1'b1;
                    wait_d      = '0;
                    state_d     = ST_CONV;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_CONV: begin
                // A done pulse coinciding with our own start pulse is stale.
                if (adc_done && !adc_start_q) begin
                    orig_d = to_offset_binary(adc_data[13:2]);
                    wait_d = '0;
                    if (mix_en) begin
                        oct_req_d = 1'b1;
                        state_d   = ST_OCT;
                    end else begin
                        oct_d     = 12'h000;
                        state_d   = ST_SUM;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            ST_OCT: begin
                if (oct_valid) begin
                    oct_d   = oct_data;
                    state_d = ST_SUM;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            ST_SUM: begin
                mix_d     = mix_sum_s;
                sdi_d     = frame_load_s[15];
                frame_d   = {frame_load_s[14:0], 1'b0};
                cs_n_d    = 1'b0;
                sclk_d    = 1'b0;
                bit_cnt_d = 5'd0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == 5'd31) begin
                    cs_n_d  = 1'b1;
                    sclk_d  = 1'b0;
                    sdi_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    sclk_d    = ~sclk_q;
                    // Next bit is presented as sclk falls, so it is stable for the rise.
                    if (sclk_q) begin
                        sdi_d   = frame_q[15];
                        frame_d = {frame_q[14:0], 1'b0};
                    end else begin
                        sdi_d   = sdi_q;
                    end
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                sdi_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= 16'd0;
            wait_q      <= '0;
            orig_q      <= 12'h000;
            oct_q       <= 12'h000;
            frame_q     <= 16'h0000;
            bit_cnt_q   <= 5'd0;
            adc_start_q <= 1'b0;
            oct_req_q   <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            sdi_q       <= 1'b0;
            mix_q       <= 12'h000;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            wait_q      <= wait_d;
            orig_q      <= orig_d;
            oct_q       <= oct_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            adc_start_q <= adc_start_d;
            oct_req_q   <= oct_req_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            sdi_q       <= sdi_d;
            mix_q       <= mix_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
        end
    end

endmodule

// File: tb/tb_mix_sequencer.sv
// Bench for mix_sequencer: a sample-level planner predicts every output per cycle
// and schedules the ADC/octave responses; one process compares each cycle.
module tb_mix_sequencer;
    localparam int SD   = 64;
    localparam int TO   = 255;
    localparam int MAXC = 16384;

    typedef struct {
        int          w;
        logic [13:0] adc;
        bit          en;
        int          v;
        logic [11:0] oct;
    } smp_t;

    logic        clk;
    logic        rst_n;
    logic        mix_en;
    logic [13:0] adc_data;
    logic        adc_done;
    logic        adc_start;
    logic [11:0] oct_data;
    logic        oct_valid;
    logic        oct_req;
    logic        dac_cs_n;
    logic        dac_sclk;
    logic        dac_sdi;
    logic [11:0] mix_out;
    logic        timeout_err;
    logic        overrun;

    mix_sequencer #(.SAMPLE_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .mix_en(mix_en),
        .adc_data(adc_data), .adc_done(adc_done), .adc_start(adc_start),
        .oct_data(oct_data), .oct_valid(oct_valid), .oct_req(oct_req),
        .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_sdi(dac_sdi),
        .mix_out(mix_out), .timeout_err(timeout_err), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit          e_start [MAXC];
    bit          e_req   [MAXC];
    bit          e_cs    [MAXC];
    bit          e_sclk  [MAXC];
    bit          e_sdi   [MAXC];
    bit          e_err   [MAXC];
    bit          e_ovr   [MAXC];
    logic [11:0] e_mix   [MAXC];
    bit          d_done  [MAXC];
    bit          d_valid [MAXC];
    bit          d_en    [MAXC];
    logic [13:0] d_adata [MAXC];
    logic [11:0] d_odata [MAXC];

    smp_t        smps[$];
    int          sum_at [64];
    int          lit_cyc[$];
    logic [11:0] lit_val[$];
    logic [15:0] frames[$];
    int          lit_idx;
    int          cyc;
    int          mode;
    int          n_chk;
    int          n_pass;
    int          last1;
    int          last2;
    logic [15:0] cap;
    bit          sclk_prev;
    bit          cs_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Signed ADC word scaled to 12 bits, shifted to mid-scale, plus octave, clamped.
    function automatic logic [11:0] model_mix(input logic [13:0] adc, input logic [11:0] oct, input bit en);
        int s;
        int total;
        s     = $signed(adc);
        total = (s >>> 2) + 2048 + (en ? int'(oct) : 0);
        if (total > 4095) total = 4095;
        return 12'(total);
    endfunction

    function automatic smp_t mk(input int w, input logic [13:0] adc, input bit en, input int v, input logic [11:0] oct);
        smp_t x;
        x.w = w; x.adc = adc; x.en = en; x.v = v; x.oct = oct;
        return x;
    endfunction

    function automatic smp_t rand_smp();
        int r;
        smp_t x;
        r   = $urandom_range(0, 15);
        x.w = (r == 0) ? -1 : int'($urandom_range(1, 24));
        r   = $urandom_range(0, 15);
        x.v = (r == 0) ? -1 : (r < 3) ? int'($urandom_range(40, 70)) : int'($urandom_range(0, 20));
        x.adc = 14'($urandom);
        x.oct = 12'($urandom);
        x.en  = 1'($urandom_range(0, 1));
        return x;
    endfunction

    // Walk the sample list on the tick grid; fill expected outputs and the input schedule.
    task automatic plan(input bit cut_last, output int last);
        int idle_from, m, a, b, s, ab;
        bit aborted;
        logic [11:0] val;
        logic [15:0] frame;
        for (int c = 0; c < MAXC; c++) begin
            e_start[c] = 0; e_req[c] = 0; e_cs[c] = 1; e_sclk[c] = 0; e_sdi[c] = 0;
            e_err[c] = 0; e_ovr[c] = 0; e_mix[c] = 12'h000;
            d_done[c] = 0; d_valid[c] = 0; d_en[c] = 1'($urandom_range(0, 1));
            d_adata[c] = 14'($urandom); d_odata[c] = 12'($urandom);
        end
        idle_from = 0; m = SD; s = 0; ab = 0;
        foreach (smps[i]) begin
            while (m - 1 < idle_from) begin e_ovr[m] = 1; m += SD; end
            e_start[m] = 1;
            d_done[m]  = 1;
            aborted    = 0;
            if (smps[i].w < 0) begin
                aborted = 1; ab = m + TO + 1;
            end else begin
                a = m + smps[i].w;
                d_done[a] = 1; d_adata[a] = smps[i].adc; d_en[a] = smps[i].en; d_valid[a] = 1;
                if (!smps[i].en) begin
                    s = a + 1; d_valid[a + 1] = 1;
                end else begin
                    e_req[a + 1] = 1;
                    if (smps[i].v < 0) begin
                        aborted = 1; ab = a + 2 + TO;
                    end else begin
                        b = a + 1 + smps[i].v;
                        d_valid[b] = 1; d_odata[b] = smps[i].oct; s = b + 1;
                    end
                end
            end
            if (aborted) begin
                for (int c = ab; c < MAXC; c++) e_err[c] = 1;
                idle_from = ab;
            end else begin
                val   = model_mix(smps[i].adc, smps[i].oct, smps[i].en);
                frame = {4'b0011, val};
                for (int c = s + 1; c < MAXC; c++) e_mix[c] = val;
                for (int j = 0; j < 32; j++) begin
                    e_cs[s + 1 + j]   = 0;
                    e_sclk[s + 1 + j] = (j % 2 == 1);
                    e_sdi[s + 1 + j]  = frame[15 - j / 2];
                end
                d_done[s + 5] = 1;
                idle_from = s + 33;
            end
            sum_at[i] = s;
            m += SD;
        end
        if (cut_last) begin
            last = s + 10;
        end else begin
            while (m - 1 < idle_from) begin e_ovr[m] = 1; m += SD; end
            last = m - 1;
        end
        if (last >= MAXC) begin
            $display("FAIL plan_length cyc=%0d actual=%0d expected=<%0d", cyc, last, MAXC);
            $fatal(1);
        end
    endtask

    task automatic drive(input int c);
        adc_done  = d_done[c];
        adc_data  = d_adata[c];
        oct_valid = d_valid[c];
        oct_data  = d_odata[c];
        mix_en    = d_en[c];
    endtask

    task automatic run_phase(input int last);
        @(posedge clk); #1;
        cyc = 0; drive(0); rst_n = 1'b1; mode = 1;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            cyc = c; drive(c);
            if (c == SD - 1) check("no_early_tick", adc_start, 0);
            if (c == SD) check("first_tick", adc_start, 1);
        end
    endtask

    // Per-cycle comparison against the plan, or against reset values while in reset.
    always @(negedge clk) begin
        if (mode == 1) begin
            check("adc_start", adc_start, e_start[cyc]);
            check("oct_req", oct_req, e_req[cyc]);
            check("dac_cs_n", dac_cs_n, e_cs[cyc]);
            check("dac_sclk", dac_sclk, e_sclk[cyc]);
            check("dac_sdi", dac_sdi, e_sdi[cyc]);
            check("mix_out", mix_out, e_mix[cyc]);
            check("timeout_err", timeout_err, e_err[cyc]);
            check("overrun", overrun, e_ovr[cyc]);
            if (lit_idx < lit_cyc.size() && cyc == lit_cyc[lit_idx]) begin
                check("mix_literal", mix_out, lit_val[lit_idx]);
                lit_idx++;
            end
        end else if (mode == 2) begin
            check("rst_adc_start", adc_start, 0);
            check("rst_oct_req", oct_req, 0);
            check("rst_cs_n", dac_cs_n, 1);
            check("rst_sclk", dac_sclk, 0);
            check("rst_sdi", dac_sdi, 0);
            check("rst_mix_out", mix_out, 12'h000);
            check("rst_timeout_err", timeout_err, 0);
            check("rst_overrun", overrun, 0);
        end
    end

    // Reassemble DAC frames from sclk rising edges.
    always @(negedge clk) begin
        if (mode == 1) begin
            if (!dac_cs_n && cs_prev) cap = 16'h0000;
            if (!dac_cs_n && dac_sclk && !sclk_prev) cap = {cap[14:0], dac_sdi};
            if (dac_cs_n && !cs_prev) frames.push_back(cap);
            sclk_prev = dac_sclk;
            cs_prev   = dac_cs_n;
        end else begin
            sclk_prev = 1'b0;
            cs_prev   = 1'b1;
        end
    end

    initial begin
        logic [15:0] exp_frames [4];
        n_chk = 0; n_pass = 0; cyc = 0; mode = 0; lit_idx = 0;
        cap = 16'h0000; sclk_prev = 1'b0; cs_prev = 1'b1;
        rst_n = 1'b0; adc_done = 1'b0; oct_valid = 1'b0; mix_en = 1'b0;
        adc_data = 14'h0000; oct_data = 12'h000;

        smps.push_back(mk(4, 14'h0000, 1, 3, 12'h100));
        smps.push_back(mk(1, 14'h1FFC, 1, 0, 12'h001));
        smps.push_back(mk(6, 14'h2000, 1, 5, 12'h000));
        smps.push_back(mk(2, 14'h3FFC, 0, 0, 12'h0AB));
        smps.push_back(mk(-1, 14'h0123, 1, 0, 12'h000));
        smps.push_back(mk(3, 14'h0456, 1, -1, 12'h000));
        smps.push_back(mk(2, 14'h0400, 1, 60, 12'h010));
        smps.push_back(mk(TO, 14'h0004, 1, TO, 12'h7FE));
        for (int i = 0; i < 30; i++) smps.push_back(rand_smp());
        smps.push_back(mk(3, 14'h1000, 1, 2, 12'h055));
        plan(1'b1, last1);

        lit_cyc.push_back(sum_at[0] + 1); lit_val.push_back(12'h900);
        lit_cyc.push_back(sum_at[1] + 1); lit_val.push_back(12'hFFF);
        lit_cyc.push_back(sum_at[2] + 1); lit_val.push_back(12'h000);
        lit_cyc.push_back(sum_at[3] + 1); lit_val.push_back(12'h7FF);
        lit_cyc.push_back(sum_at[6] + 1); lit_val.push_back(12'h910);
        lit_cyc.push_back(sum_at[7] + 1); lit_val.push_back(12'hFFF);
        lit_cyc.push_back(sum_at[38] + 1); lit_val.push_back(12'hC55);

        @(posedge clk); #1;
        mode = 2;
        run_phase(last1);
        check("timeout_err_sticky", timeout_err, 1);
        check("cut_at_5th_rise", dac_sclk, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        mode = 2; cyc = -1;
        check("lit_all_seen", lit_idx, 7);

        exp_frames[0] = 16'h3900; exp_frames[1] = 16'h3FFF;
        exp_frames[2] = 16'h3000; exp_frames[3] = 16'h37FF;
        for (int k = 0; k < 4; k++) begin
            check("frame_literal", (frames.size() > k) ? {16'h0000, frames[k]} : 32'hDEAD0000,
                  {16'h0000, exp_frames[k]});
        end

        smps.delete();
        lit_cyc.delete(); lit_val.delete(); lit_idx = 0;
        for (int i = 0; i < 8; i++) smps.push_back(rand_smp());
        plan(1'b0, last2);
        run_phase(last2);

        mode = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mix_sequencer.md
Name: mix_sequencer

Overview:
- Per-sample controller for the octaver datapath.
- On each sample tick it starts an ADC conversion, then waits for the converted word.
- It then requests an octave sample and waits for it.
- It converts the ADC word to 12-bit offset-binary and forms the saturating sum with the octave.
- It shifts the 12-bit result to the serial DAC and sits between the ADC front-end, the octave generator and the DAC.

Parameters:
- SAMPLE_DIV, 2500, clock cycles per sample period (50 MHz / 20 kHz); legal range 64..65535.
- TIMEOUT, 255, maximum cycles spent waiting in CONV or OCT before the sample is aborted.
- DAC_CMD, 4'b0011, command nibble prefixed to every DAC frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- mix_en  input  1  1: output original+octave; 0: output original only
- adc_data  input  14  two's-complement ADC word, valid when adc_done=1
- adc_done  input  1  one-cycle pulse, conversion complete
- adc_start  output  1  one-cycle pulse, start conversion
- oct_data  input  12  unsigned octave sample, valid when oct_valid=1
- oct_valid  input  1  one-cycle pulse, octave sample ready
- oct_req  output  1  one-cycle pulse, request octave sample
- dac_cs_n  output  1  DAC chip select, active-low
- dac_sclk  output  1  DAC serial clock
- dac_sdi  output  1  DAC serial data
- mix_out  output  12  last value sent to DAC, registered
- timeout_err  output  1  sticky, set on any abort; cleared only by reset
- overrun  output  1  one-cycle pulse when a tick arrives outside IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - state IDLE, tick counter 0.
  - adc_start=0, oct_req=0.
  - dac_cs_n=1, dac_sclk=0, dac_sdi=0.
  - mix_out=12'h000, timeout_err=0, overrun=0.
- Tick counter:
  - Free-running, counts 0..SAMPLE_DIV-1 and wraps.
  - tick is asserted for one cycle when the count equals SAMPLE_DIV-1.
  - First tick occurs SAMPLE_DIV cycles after reset release.
- FSM states: IDLE, CONV, OCT, SUM, SHIFT.
- IDLE:
  - On tick: adc_start=1 for one cycle, clear wait counter, go to CONV.
- CONV:
  - On adc_done: capture orig = adc_data[13:2] ^ 12'h800 (truncate the 2 LSBs, convert to offset-binary).
  - In the same cycle: pulse oct_req, clear wait counter, go to OCT.
  - If mix_en=0: skip OCT, set oct=0, go to SUM.
  - If the wait counter reaches TIMEOUT: set timeout_err, return to IDLE. mix_out is unchanged and nothing is sent to the DAC.
- OCT:
  - On oct_valid: capture oct_data, go to SUM.
  - Timeout is handled as in CONV.
- SUM (1 cycle):
  - sum13 = {0,orig} + {0,oct}.
  - mix_out = sum13[12] ? 12'hFFF : sum13[11:0].
  - Load the 16-bit frame {DAC_CMD, mix_out}, go to SHIFT.
- SHIFT:
  - dac_cs_n=0 for 32 cycles; sclk = clk/2.
  - dac_sdi changes while dac_sclk is low; dac_sclk rises on odd cycles; MSB first.
  - After the 16th rising edge: dac_cs_n=1, dac_sclk=0, go to IDLE.
- Latency: tick to cs_n falling = 3 + conversion wait + octave wait cycles; a full frame takes 32 cycles.
- Simultaneous events:
  - adc_done in the same cycle as adc_start is ignored; acceptance starts the cycle after entering CONV.
  - adc_done/oct_valid outside their wait state are ignored.
  - A done/valid pulse arriving in the same cycle the wait counter hits TIMEOUT is accepted (it wins over the timeout).
- overrun: a tick arriving in any state other than IDLE pulses overrun for one cycle and is dropped; the current sample completes normally.
- mix_en is sampled only in CONV at the adc_done cycle; a change mid-sample affects the next sample only.
- Reset mid-frame: the next clock with rst_n=0 forces all reset values. dac_cs_n returns to 1 immediately and the partial frame is abandoned.

Test Plan:
- Basic sum: adc_data=14'h0000, oct_data=12'h100, mix_en=1 -> orig=12'h800, mix_out=12'h900, frame 16'h3900 shifted MSB first across 16 sclk rising edges.
- Saturation: adc_data=14'h1FFC (orig=12'hFFF), oct_data=12'h001 -> mix_out=12'hFFF, frame 16'h3FFF. Repeat with adc_data=14'h2000, oct=12'h000 -> mix_out=12'h000.
- Bypass: mix_en=0, adc_data=14'h3FFC -> oct_req never pulses, mix_out=12'h7FF.
- Timeout: withhold adc_done -> after TIMEOUT cycles FSM returns to IDLE, timeout_err=1 (sticky), dac_cs_n stays 1, mix_out keeps its previous value. Also withhold oct_valid -> same response.
- Overrun: SAMPLE_DIV=64, delay oct_valid 60 cycles -> overrun pulses once at the next tick, and the following sample starts only at the tick after that.
- Reset mid-SHIFT: drop rst_n at the 5th sclk rise -> next cycle dac_cs_n=1, dac_sclk=0, mix_out=0, state IDLE; the next tick comes SAMPLE_DIV cycles after release.
